// File: rtl/bus_pkg.sv
// Shared host-bus types and register addresses.
// Used by the OAM DMA sequencer and by the chip-select / widget decode, so the
// trigger and destination addresses live in exactly one place.
//   addr_t       16-bit CPU bus address
//   data_t       8-bit CPU bus data
//   dma_state_t  OAM DMA sequencer states (also visible to benches)
package bus_pkg;

    typedef logic [15:0] addr_t;
    typedef logic [7:0]  data_t;

    localparam addr_t ADDR_OAMDMA  = 16'h4014;
    localparam addr_t ADDR_OAMDATA = 16'h2004;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE,
        DONE
    } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// Sprite OAM DMA sequencer.
// A core write of page P to the trigger address halts the core, then the DMA
// owns the bus and copies $PP00-$PPFF to the OAMDATA port, one read on a
// "get" (parity=0) CPU cycle followed by one write on the next cycle.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a core write to the trigger address
// HALT  | core asked to halt; waiting for its first read cycle
// ALIGN | one dummy DMA cycle so reads land on parity=0 cycles
// READ  | DMA reads {page, idx}; data latched at the cycle tick
// WRITE | DMA writes latched byte to OAMDATA; idx advances
// DONE  | one-clock hand-back to IDLE, core released
//
// Ports:
//   I_clock        system clock
//   I_reset        synchronous active-high reset
//   I_cpu_tick     strobe on the last I_clock of every CPU bus cycle
//   I_core_addr    core address, used only for trigger decode
//   I_core_rdwr    core direction, 1 = read
//   I_core_wr_data core write data (page number on trigger)
//   I_rd_data      bus read data after chip-select mux
//   O_ready        to core ready input; 0 halts the core
//   O_bus_own      1 while the DMA drives the bus this CPU cycle
//   O_addr         DMA bus address
//   O_rdwr         DMA direction, 1 = read
//   O_wr_data      DMA write data
//   O_busy         transfer pending or in progress
module oam_dma
    import bus_pkg::*;
#(
    parameter addr_t P_trigger_addr = ADDR_OAMDMA,
    parameter addr_t P_dest_addr    = ADDR_OAMDATA
) (
    input  logic        I_clock,
    input  logic        I_reset,
    input  logic        I_cpu_tick,
    input  logic [15:0] I_core_addr,
    input  logic        I_core_rdwr,
    input  logic [7:0]  I_core_wr_data,
    input  logic [7:0]  I_rd_data,
    output logic        O_ready,
    output logic        O_bus_own,
    output logic [15:0] O_addr,
    output logic        O_rdwr,
    output logic [7:0]  O_wr_data,
    output logic        O_busy
);

    dma_state_t state_q, state_d;
    data_t      idx_q, idx_d;
    data_t      page_q, page_d;
    logic       parity_q;
    logic       ready_q, ready_d;
    logic       own_q, own_d;
    logic       rdwr_q, rdwr_d;
    logic       busy_q, busy_d;
    addr_t      addr_q, addr_d;
    data_t      wr_data_q, wr_data_d;
    logic       trigger;

    assign trigger = I_cpu_tick & ~I_core_rdwr & (I_core_addr == P_trigger_addr);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        page_d    = page_q;
        ready_d   = ready_q;
        own_d     = own_q;
        rdwr_d    = rdwr_q;
        busy_d    = busy_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    page_d  = I_core_wr_data;
                    idx_d   = 8'h00;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = HALT;
                end
            end
            HALT: begin
                // Core write cycles cannot be halted; the first read is the halt cycle.
                if (I_cpu_tick && I_core_rdwr) begin
                    own_d  = 1'b1;
                    rdwr_d = 1'b1;
                    // The cycle after this one has parity ~parity_q; reads must be on parity 0.
                    if (parity_q == 1'b0) begin
                        addr_d  = P_dest_addr;
                        state_d = ALIGN;
                    end else begin
                        addr_d  = {page_q, idx_q};
                        state_d = READ;
                    end
                end
            end
            ALIGN: begin
                if (I_cpu_tick) begin
                    addr_d  = {page_q, idx_q};
                    state_d = READ;
                end
            end
            READ: begin
                if (I_cpu_tick) begin
                    wr_data_d = I_rd_data;
                    rdwr_d    = 1'b0;
                    addr_d    = P_dest_addr;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                if (I_cpu_tick) begin
                    idx_d  = idx_q + 8'd1;
                    rdwr_d = 1'b1;
                    if (idx_q == 8'hFF) begin
                        own_d   = 1'b0;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        addr_d  = {page_q, idx_d};
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            state_q   <= IDLE;
            idx_q     <= 8'h00;
            page_q    <= 8'h00;
            parity_q  <= 1'b0;
            ready_q   <= 1'b1;
            own_q     <= 1'b0;
            rdwr_q    <= 1'b1;
            busy_q    <= 1'b0;
            addr_q    <= 16'h0000;
            wr_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            page_q    <= page_d;
            if (I_cpu_tick) begin
                parity_q <= ~parity_q;
            end
            ready_q   <= ready_d;
            own_q     <= own_d;
            rdwr_q    <= rdwr_d;
            busy_q    <= busy_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign O_ready   = ready_q;
    assign O_bus_own = own_q;
    assign O_addr    = addr_q;
    assign O_rdwr    = rdwr_q;
    assign O_wr_data = wr_data_q;
    assign O_busy    = busy_q;

endmodule

// File: tb/tb_oam_dma.sv
module tb_oam_dma;
    import bus_pkg::*;

    logic  clk = 1'b0;
    logic  rst;
    logic  tick;
    addr_t core_addr;
    logic  core_rdwr;
    data_t core_wd;
    data_t rd_data;
    logic  ready, own, rdwr, busy;
    addr_t addr;
    data_t wd;

    data_t mem [0:65535];
    int    tests = 0;
    int    fails = 0;
    int    par   = 0;

    logic  s_ready, s_own, s_rdwr, s_busy;
    addr_t s_addr;
    data_t s_wd;
    int    s_par;

    always #5 clk = ~clk;

    assign rd_data = mem[addr];

    oam_dma dut (
        .I_clock        (clk),
        .I_reset        (rst),
        .I_cpu_tick     (tick),
        .I_core_addr    (core_addr),
        .I_core_rdwr    (core_rdwr),
        .I_core_wr_data (core_wd),
        .I_rd_data      (rd_data),
        .O_ready        (ready),
        .O_bus_own      (own),
        .O_addr         (addr),
        .O_rdwr         (rdwr),
        .O_wr_data      (wd),
        .O_busy         (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First half of a CPU cycle: drive core inputs, raise tick, sample bus state.
    task automatic cyc_a(input addr_t a, input logic rw, input data_t d);
        core_addr = a;
        core_rdwr = rw;
        core_wd   = d;
        tick      = 1'b0;
        @(posedge clk); #1;
        tick = 1'b1;
        @(negedge clk);
        s_ready = ready; s_own = own; s_rdwr = rdwr; s_busy = busy;
        s_addr  = addr;  s_wd  = wd;  s_par  = par;
    endtask

    // Second half: the tick edge.
    task automatic cyc_b();
        @(posedge clk); #1;
        tick = 1'b0;
        if (rst) par = 0; else par ^= 1;
    endtask

    task automatic idle_read();
        cyc_a(16'h8000, 1'b1, 8'h00);
        cyc_b();
    endtask

    task automatic set_par(input int want);
        if (par != want) idle_read();
    endtask

    // One full transfer driven from the core side and checked against the
    // expected sequence of DMA bus cycles built from the transfer rules.
    task automatic transfer(input data_t pg, input int nw, input bit inject, input int rst_at);
        logic [24:0] got[$];
        int          gpar[$];
        logic [24:0] exp_q[$];
        int          low = 0, cyc = 0, wcnt = 0, trig_par, halt_par, align, bad;
        bit          own_early = 1'b0, done = 1'b0, fin_busy = 1'b1, fin_own = 1'b1;
        addr_t       a;
        logic        rw;
        data_t       d;
        trig_par = par;
        cyc_a(ADDR_OAMDMA, 1'b0, pg);
        cyc_b();
        while (!done && cyc < 700) begin
            d  = data_t'($urandom);
            a  = addr_t'($urandom);
            rw = 1'b1;
            if (cyc < nw) begin
                rw = 1'b0;
                a  = 16'h0100 + addr_t'(cyc);
            end else if (inject && cyc == 50) begin
                rw = 1'b0; a = ADDR_OAMDMA; d = 8'h05;
            end else if (inject && cyc == 60) begin
                rw = 1'b0; a = 16'h4015; d = 8'h05;
            end
            cyc_a(a, rw, d);
            if (!s_ready) low++;
            if (cyc <= nw && s_own) own_early = 1'b1;
            if (s_own) begin
                got.push_back({s_rdwr, s_addr, s_rdwr ? 8'h00 : s_wd});
                gpar.push_back(s_par);
                if (!s_rdwr) wcnt++;
            end
            if (rst_at > 0 && s_own && !s_rdwr && wcnt == rst_at) begin
                rst = 1'b1;
                cyc_b();
                chk("rst_mid_ready", 32'(ready), 32'd1);
                chk("rst_mid_own", 32'(own), 32'd0);
                chk("rst_mid_busy", 32'(busy), 32'd0);
                chk("rst_mid_rdwr", 32'(rdwr), 32'd1);
                rst = 1'b0;
                return;
            end
            if (s_ready && low > 0) begin
                done     = 1'b1;
                fin_busy = s_busy;
                fin_own  = s_own;
            end
            cyc_b();
            cyc++;
        end
        halt_par = (trig_par + 1 + nw) % 2;
        align    = (halt_par == 0) ? 1 : 0;
        if (align == 1) exp_q.push_back({1'b1, ADDR_OAMDATA, 8'h00});
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back({1'b1, pg, 8'(i), 8'h00});
            exp_q.push_back({1'b0, ADDR_OAMDATA, mem[{pg, 8'(i)}]});
        end
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= got.size() || got[i] !== exp_q[i]) bad++;
        end
        chk("xfer_done", 32'(done), 32'd1);
        chk("ready_low_ticks", 32'(low), 32'(nw + 1 + align + 512));
        chk("bus_cycle_count", 32'(got.size()), 32'(exp_q.size()));
        chk("bus_seq_mismatches", 32'(bad), 32'd0);
        chk("own_before_halt", 32'(own_early), 32'd0);
        if (got.size() > align) chk("first_read_parity", 32'(gpar[align]), 32'd0);
        else chk("first_read_missing", 32'(got.size()), 32'(align + 1));
        chk("end_busy", 32'(fin_busy), 32'd0);
        chk("end_own", 32'(fin_own), 32'd0);
    endtask

    initial begin
        int owns;
        for (int i = 0; i < 65536; i++) mem[i] = data_t'($urandom);
        rst = 1'b1; tick = 1'b0;
        core_addr = 16'h0000; core_rdwr = 1'b1; core_wd = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_own", 32'(own), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_rdwr", 32'(rdwr), 32'd1);
        chk("rst_wdata", 32'(wd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        par = 0;

        // Non-trigger accesses leave the DMA idle.
        cyc_a(16'h4015, 1'b0, 8'h02); cyc_b();
        cyc_a(ADDR_OAMDMA, 1'b1, 8'h02); cyc_b();
        cyc_a(16'h8000, 1'b1, 8'h00);
        chk("no_trigger_busy", 32'(s_busy), 32'd0);
        cyc_b();

        set_par(0); transfer(8'h02, 0, 1'b0, 0);
        set_par(1); transfer(8'h02, 0, 1'b0, 0);
        set_par(0); transfer(8'h07, 2, 1'b0, 0);
        set_par(1); transfer(8'h02, 0, 1'b1, 0);

        set_par(0); transfer(8'h02, 0, 1'b0, 100);
        owns = 0;
        for (int i = 0; i < 10; i++) begin
            cyc_a(16'h8000, 1'b1, 8'h00);
            if (s_own) owns++;
            cyc_b();
        end
        chk("post_rst_no_dma", 32'(owns), 32'd0);
        transfer(8'h03, 0, 1'b0, 0);

        set_par(1); transfer(8'hFF, 0, 1'b0, 0);
        set_par(0); transfer(8'h20, 1, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
